progmem_prefetch: RTL
=====================

Name: progmem_prefetch

Overview:
- Instruction-fetch prefetcher that sits directly upstream of the program-memory read slave.
- Acts as the Avalon-style read master toward progmem and issues sequential word reads.
- Buffers returned words, with their addresses and error flags, in a small FIFO.
- Presents them to the CPU core over a valid/ready stream, and supports PC redirect (branch/jump/trap) with flush.

Parameters:
- DEPTH, 4, FIFO entries; power of two, range 2..16.
- ADDR_W, 10, word-address width of program memory.
- RESET_ADDR, 0, fetch address loaded at reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  fetching allowed; 0 = no new reads issued
- redirect  in  1  single-cycle pulse: flush and restart fetch at redirect_addr
- redirect_addr  in  ADDR_W  new fetch word address
- mem_address  out  ADDR_W  read address to progmem
- mem_read  out  1  read request
- mem_readdata  in  32  read data, valid in the accept cycle
- mem_response  in  2  0 = OK, nonzero = error, valid in the accept cycle
- mem_waitrequest  in  1  slave stall
- inst_valid  out  1  FIFO head valid
- inst_data  out  32  instruction word at head
- inst_addr  out  ADDR_W  word address of head
- inst_err  out  1  head was fetched with nonzero response
- inst_ready  in  1  core consumes head when inst_valid && inst_ready

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - mem_read=0, mem_address=0, inst_valid=0, inst_data=0, inst_addr=0, inst_err=0.
  - FIFO count=0; fetch_addr=RESET_ADDR; state=IDLE.
- Accept: a cycle with mem_read=1 and mem_waitrequest=0. mem_readdata and mem_response are sampled in that cycle.
- Hold rule: while mem_read=1 and mem_waitrequest=1, mem_address and mem_read stay stable, including across redirect.
- State machine:
  - IDLE: mem_read=0.
    - If fetch_en && count<DEPTH && !redirect: next cycle REQ, with mem_address<=fetch_addr, mem_read<=1.
  - REQ: mem_read=1.
    - On accept: push {mem_address, mem_readdata, mem_response!=0}; fetch_addr<=fetch_addr+1, wrapping 2^ADDR_W-1 -> 0.
    - After the accept, stay in REQ with mem_address<=fetch_addr+1 if fetch_en and next-state count<DEPTH; else go IDLE.
    - Back-to-back accepts give one word per cycle.
  - DROP: an in-flight read is being discarded after a redirect. mem_read=1 with the old address.
    - On accept: data is not pushed; go REQ at fetch_addr if fetch_en, else IDLE.
- Redirect, any state:
  - FIFO flushed (count<=0, inst_valid<=0 next cycle); fetch_addr<=redirect_addr.
  - IDLE -> IDLE; request issued the following cycle if fetch_en.
  - REQ, no accept this cycle -> DROP.
  - REQ with accept the same cycle: accepted word discarded -> IDLE.
  - DROP -> DROP; fetch_addr updated to the latest redirect_addr.
  - Redirect has priority over a pop and a push in the same cycle.
- Space guarantee: a read is only started when count<DEPTH. Count cannot rise while a read is pending, so an accept never overflows.
- Push and pop in the same cycle: count unchanged, order preserved.
- Pop on empty: ignored.
- Outputs:
  - FIFO outputs are registered; no bypass.
  - A word accepted in cycle t appears on inst_* at t+1 at the earliest.
- fetch_en deassert: does not abort a pending read. The read completes and is pushed; then IDLE.
- Reset mid-read: all state cleared immediately; mem_read drops asynchronously.
- Error words are passed through with inst_err=1. Fetch continues sequentially.

Test Plan:
- Reset, then fetch_en=1 with slave waitrequest=1 for 1 cycle per read, inst_ready=1 -> mem_address sequence 0,1,2,3…; inst_addr/inst_data match ROM contents in order; no gaps beyond slave stalls.
- inst_ready=0, DEPTH=4 -> exactly 4 accepts, then mem_read=0 and inst_valid=1 with inst_addr=0. Release ready -> fetch resumes at address 4.
- Redirect to 0x200 while mem_read=1 and waitrequest=1 at address 5 -> address 5 held until accept and discarded; next request is address 0x200; first inst_addr after the flush is 0x200.
- Redirect coincident with an accept of address 7 -> word 7 never appears on inst_*; fetch restarts at redirect_addr.
- Start at 0x3FE -> addresses 0x3FE, 0x3FF, 0x000 in order; inst_addr wraps identically.
- Slave returns mem_response=2 on address 3 -> inst_err=1 only for inst_addr=3; other words have inst_err=0; async reset mid-stall -> mem_read=0 and inst_valid=0 immediately, and fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/progmem_prefetch.sv
// progmem_prefetch: sequential instruction-fetch engine in front of the program
// memory. Issues Avalon-style word reads, queues returned words with their
// address and error flag in a shift-register FIFO whose head drives the
// instruction stream directly from flops, and flushes/restarts on PC redirect.
module progmem_prefetch #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [31:0]       mem_readdata,
    input  logic [1:0]        mem_response,
    input  logic              mem_waitrequest,
    output logic              inst_valid,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              inst_err,
    input  logic              inst_ready
);

    localparam int unsigned       CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   fetch_addr_q;
    logic [ADDR_W-1:0]   mem_address_q;
    logic                mem_read_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                accept_s;
    logic                push_s;
    logic                pop_s;
    logic [CW-1:0]       widx_s;

    // Shift-register FIFO: entry 0 is always the head, so inst_* come straight from flops.
    logic [ADDR_W-1:0]   ent_addr_q [DEPTH];
    logic [31:0]         ent_data_q [DEPTH];
    logic [DEPTH-1:0]    ent_err_q;
    logic [DEPTH-1:0]    ent_vld_q;
    logic [ADDR_W-1:0]   ent_addr_d [DEPTH];
    logic [31:0]         ent_data_d [DEPTH];
    logic [DEPTH-1:0]    ent_err_d;
    logic [DEPTH-1:0]    ent_vld_d;

    assign accept_s = mem_read_q & ~mem_waitrequest;
    // Redirect wins over both push and pop; a word accepted during DROP is never pushed.
    assign push_s   = accept_s & (state_q == ST_REQ) & ~redirect;
    assign pop_s    = ent_vld_q[0] & inst_ready & ~redirect;
    assign widx_s   = pop_s ? (count_q - CNT_ONE) : count_q;

    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign inst_valid  = ent_vld_q[0];
    assign inst_data   = ent_data_q[0];
    assign inst_addr   = ent_addr_q[0];
    assign inst_err    = ent_err_q[0];

    // Next FIFO occupancy, used both for the FIFO and for the keep-fetching decision.
    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Next FIFO contents: shift on pop, then write the pushed word behind the last valid entry.
    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_err_d  = ent_err_q;
        ent_vld_d  = ent_vld_q;
        if (redirect) begin
            ent_vld_d = '0;
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_addr_d[i] = pop_s ? ent_addr_q[i+1] : ent_addr_q[i];
                ent_data_d[i] = pop_s ? ent_data_q[i+1] : ent_data_q[i];
                ent_err_d[i]  = pop_s ? ent_err_q[i+1]  : ent_err_q[i];
                ent_vld_d[i]  = pop_s ? ent_vld_q[i+1]  : ent_vld_q[i];
            end
            ent_vld_d[DEPTH-1] = pop_s ? 1'b0 : ent_vld_q[DEPTH-1];
            for (int i = 0; i < DEPTH; i++) begin
                if (push_s && (CW'(i) == widx_s)) begin
                    ent_addr_d[i] = mem_address_q;
                    ent_data_d[i] = mem_readdata;
                    ent_err_d[i]  = (mem_response != 2'b00);
                    ent_vld_d[i]  = 1'b1;
                end else begin
                    ent_vld_d[i]  = ent_vld_d[i];
                end
            end
        end
    end

    // FIFO storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= 32'd0;
            end
            ent_err_q <= '0;
            ent_vld_q <= '0;
            count_q   <= '0;
        end else begin
            ent_addr_q <= ent_addr_d;
            ent_data_q <= ent_data_d;
            ent_err_q  <= ent_err_d;
            ent_vld_q  <= ent_vld_d;
            count_q    <= count_d;
        end
    end

    // Read-master FSM; mem_address/mem_read are held while the slave stalls, redirect included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fetch_addr_q  <= ADDR_W'(RESET_ADDR);
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redirect) begin
                        fetch_addr_q <= redirect_addr;
                    end else if (fetch_en && (count_q < DEPTH_C)) begin
                        state_q       <= ST_REQ;
                        mem_address_q <= fetch_addr_q;
                        mem_read_q    <= 1'b1;
                    end else begin
                        mem_read_q    <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (redirect) begin
                        fetch_addr_q <= redirect_addr;
                        if (accept_s) begin
                            state_q    <= ST_IDLE;
                            mem_read_q <= 1'b0;
                        end else begin
                            state_q    <= ST_DROP;
                        end
                    end else if (accept_s) begin
                        fetch_addr_q <= fetch_addr_q + ADDR_ONE;
                        if (fetch_en && (count_d < DEPTH_C)) begin
                            mem_address_q <= fetch_addr_q + ADDR_ONE;
                        end else begin
                            state_q    <= ST_IDLE;
                            mem_read_q <= 1'b0;
                        end
                    end else begin
                        mem_read_q <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (redirect) begin
                        fetch_addr_q <= redirect_addr;
                    end else begin
                        fetch_addr_q <= fetch_addr_q;
                    end
                    if (accept_s) begin
                        if (fetch_en) begin
                            state_q       <= ST_REQ;
                            mem_address_q <= redirect ? redirect_addr : fetch_addr_q;
                            mem_read_q    <= 1'b1;
                        end else begin
                            state_q    <= ST_IDLE;
                            mem_read_q <= 1'b0;
                        end
                    end else begin
                        mem_read_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    mem_read_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
